endfunction_cache: RTL and testbench
====================================

# endfunction_cache

Word-granular, direct-mapped, write-through data cache with hit/miss statistics. It sits between a load/store request source and a slower backing memory with a request/acknowledge handshake. It has 256 sets of `2**WORD_BITS` words each, and every word slot has its own valid bit and tag. The hit/miss counters let software compute hit and miss ratios.

## Interface
Parameters:
- `WORD_BITS`, default 2: log2 of words per line; total word slots = 256·2^WORD_BITS.
- `DATA_W`, default 7: data word width.
- `ADDR_W`, fixed at 32: word address width.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: high only in IDLE.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_addr`, in, 32: word address.
- `req_wdata`, in, DATA_W: store data.
- `rsp_valid`, out, 1: one-cycle response pulse.
- `rsp_hit`, out, 1: the completed access was a hit.
- `rsp_rdata`, out, DATA_W: load data; 0 for stores.
- `mem_req`, out, 1: memory access request, held until `mem_ack`.
- `mem_write`, out, 1: 1 = memory write.
- `mem_addr`, out, 32: memory word address; equals the captured `req_addr`.
- `mem_wdata`, out, DATA_W: memory write data.
- `mem_rdata`, in, DATA_W: memory read data, valid with `mem_ack`.
- `mem_ack`, in, 1: memory completes the access this cycle.
- `clear_stats`, in, 1: synchronous clear of both counters.
- `hit_count`, out, 32: number of hits.
- `miss_count`, out, 32: number of misses.

## Operation
- Address split, with L = WORD_BITS:
  - set = addr[L+7:L]
  - word = addr[L-1:0]
  - tag = addr[31:L+8], which is 24−L bits wide.
- Each slot (set, word) holds: valid, tag, data.
- Load:
  - Slot valid and tag equal: hit. Return the cached data; no memory access.
  - Otherwise: miss. Read memory at addr, write the slot (valid=1, tag, data=mem_rdata), and return mem_rdata.
- Store (write-through):
  - Slot invalid: miss. Write memory only; the slot stays invalid (no allocate).
  - Slot valid and tag equal: hit. Update the slot data and write memory.
  - Slot valid and tag unequal: miss. Overwrite the slot tag and data with the store, keep valid=1, and write memory.
- Every accepted request increments exactly one of `hit_count` or `miss_count`.
  - Counters saturate at 0xFFFF_FFFF.
  - `clear_stats` zeroes both counters and takes priority over a same-cycle increment.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
  - IDLE → LOOKUP on `req_valid`. Request fields are captured on this edge.
  - LOOKUP compares the slot and updates the counter. It then goes to:
    - RESP on a load hit;
    - MEM_RD on a load miss;
    - MEM_WR on any store (the slot update is done in LOOKUP).
  - MEM_RD / MEM_WR drive `mem_req`=1 with stable address and data until `mem_ack`, then go to RESP. The load fill is written on the `mem_ack` edge.
  - RESP asserts `rsp_valid` for one cycle, then returns to IDLE.
- Reset: all valid bits cleared, counters 0, state IDLE. All outputs are 0 except `req_ready`=1.

## Timing
- Request accepted at edge 0.
- Load hit: `rsp_valid` is high during cycle 2, two cycles after acceptance.
- Miss or store: `mem_req` rises in cycle 2.
  - After `mem_ack` is sampled high at edge N, `rsp_valid` is high in cycle N+1.
  - `mem_ack` arriving in the first `mem_req` cycle is legal.
- Counters reflect the access from the cycle after LOOKUP.
- `mem_req` may stay high indefinitely; there is no timeout.
- `mem_ack` outside MEM_RD or MEM_WR is ignored.
- `req_valid` while `req_ready`=0 is ignored; the source must hold it.
- Throughput is at most one request every 3 cycles.
- `rst` mid-transaction:
  - Outputs clear immediately (asynchronously).
  - The in-flight request is dropped and is not counted.
  - All cache contents are invalidated.

## Test plan
All scenarios use WORD_BITS=2, memory model with 1-cycle `mem_ack`.
- Reset, then load 0x0000_0104 with mem_rdata=0x15 → one read at 0x104; `rsp_rdata`=0x15, `rsp_hit`=0; miss_count=1.
- Repeat load 0x0000_0104 → no `mem_req`; `rsp_valid` 2 cycles after acceptance; `rsp_rdata`=0x15, `rsp_hit`=1; hit_count=1.
- Load 0x0000_0504 (same set and word, tag 1), then 0x0000_0104 → both miss with memory reads; miss_count=3.
- From reset, store 0x0000_0200 data 0x2A → memory write 0x2A, miss. Then load 0x0000_0200 → miss, memory read (no allocate).
- Load 0x0000_0104, store 0x0000_0104 data 0x33, load 0x0000_0104 → the store is a hit with a memory write of 0x33; the final load hits, returns 0x33, and issues no `mem_req`.
- Assert `rst` while `mem_req`=1 in MEM_RD → `mem_req`, `rsp_valid` and counters are 0 at once; a later load of a previously cached address misses.

Source files
------------

// File: rtl/endfunction_cache_if.sv
// Bundle of the request/response, backing-memory and statistics signals of endfunction_cache.
// The cache takes the slave side; the load/store source, memory and stats reader take the master side.
interface endfunction_cache_if #(
   parameter int DATA_W = 7
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [31:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic              rsp_hit;
   logic [DATA_W-1:0] rsp_rdata;

   logic              mem_req;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;

   logic              clear_stats;
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ack, clear_stats,
      output req_ready, rsp_valid, rsp_hit, rsp_rdata, mem_req, mem_write, mem_addr, mem_wdata,
             hit_count, miss_count
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_rdata, mem_ack, clear_stats,
      input  req_ready, rsp_valid, rsp_hit, rsp_rdata, mem_req, mem_write, mem_addr, mem_wdata,
             hit_count, miss_count
   );
endinterface

// File: rtl/endfunction_cache.sv
// Word-granular direct-mapped write-through cache (per-word valid/tag) with saturating
// hit/miss counters. Stores allocate only into a slot that is already valid.
module endfunction_cache #(
   parameter int WORD_BITS = 2,
   parameter int DATA_W    = 7,
   parameter int ADDR_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   endfunction_cache_if.slave  bus,
   output logic [2:0]          dbg_state
);
   localparam int IDX_W = WORD_BITS + 8;
   localparam int TAG_W = ADDR_W - IDX_W;
   localparam int NSLOT = 1 << IDX_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic              hit_q;
   logic [DATA_W-1:0] rdata_q;
   logic [31:0]       hit_cnt_q, miss_cnt_q;

   logic [NSLOT-1:0]  valid_q;
   logic [TAG_W-1:0]  tag_mem  [NSLOT];
   logic [DATA_W-1:0] data_mem [NSLOT];

   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic              slot_valid;
   logic              lookup_hit;
   logic              inc_hit, inc_miss;

   // {set, word} concatenate to the low address bits, so the slot index is a plain slice.
   assign idx        = addr_q[IDX_W-1:0];
   assign tag        = addr_q[ADDR_W-1:IDX_W];
   assign slot_valid = valid_q[idx];
   assign lookup_hit = slot_valid && (tag_mem[idx] == tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      inc_hit  = 1'b0;
      inc_miss = 1'b0;
      case (state_q)
         IDLE:   if (bus.req_valid) state_d = LOOKUP;
         LOOKUP: begin
            inc_hit  = lookup_hit;
            inc_miss = !lookup_hit;
            if (write_q)         state_d = MEM_WR;
            else if (lookup_hit) state_d = RESP;
            else                 state_d = MEM_RD;
         end
         MEM_RD, MEM_WR: if (bus.mem_ack) state_d = RESP;
         RESP:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshakes: a request transfers on a rising edge where req_valid && req_ready; the source
   // holds it until then. mem_req holds address/data stable until the edge where mem_ack is high.
   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_hit   = (state_q == RESP) && hit_q;
   assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : '0;
   assign bus.mem_req   = (state_q == MEM_RD) || (state_q == MEM_WR);
   assign bus.mem_write = (state_q == MEM_WR);
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.hit_count = hit_cnt_q;
   assign bus.miss_count = miss_cnt_q;
   assign dbg_state     = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         hit_q   <= 1'b0;
         rdata_q <= '0;
         valid_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               write_q <= bus.req_write;
               hit_q   <= 1'b0;
               rdata_q <= '0;
            end
            LOOKUP: begin
               hit_q <= lookup_hit;
               if (!write_q && lookup_hit) rdata_q <= data_mem[idx];
            end
            MEM_RD: if (bus.mem_ack) begin
               valid_q[idx] <= 1'b1;
               rdata_q      <= bus.mem_rdata;
            end
            default: ;
         endcase
      end
   end

   // Tag/data arrays need no reset: every read is qualified by valid_q.
   always_ff @(posedge clk) begin
      if (state_q == LOOKUP && write_q && slot_valid) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= wdata_q;
      end else if (state_q == MEM_RD && bus.mem_ack) begin
         tag_mem[idx]  <= tag;
         data_mem[idx] <= bus.mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (bus.clear_stats) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (inc_hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
         if (inc_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end
endmodule

// File: tb/tb_endfunction_cache.sv
// Directed bench for endfunction_cache: vector table of accesses plus hand-written sequences
// for stats clear, slow memory acks, stray acks and reset during a memory read.
module tb_endfunction_cache;
   localparam int DW = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [2:0] dbg_state;

   endfunction_cache_if #(.DATA_W(DW)) bus ();

   endfunction_cache #(.WORD_BITS(2), .DATA_W(DW), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          write;
      logic [31:0]   addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] mem_rdata;
      logic          exp_hit;
      logic [DW-1:0] exp_rdata;
      logic [31:0]   exp_hits;
      logic [31:0]   exp_misses;
   } vec_t;

   vec_t vecs[15];
   logic [DW-1:0] exp_q[$];
   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Drives one request and acts as the memory, acking after ack_delay mem_req cycles.
   task automatic access(input vec_t v, input int ack_delay, input string name);
      int lat, waited;
      bit got_rsp, saw_mem, unstable;
      logic [31:0] m_addr;
      logic m_write;
      logic [DW-1:0] m_wdata, r_data, e_data;
      logic r_hit;
      bit exp_mem;
      exp_mem = v.write || !v.exp_hit;
      m_addr = '0; m_write = 1'b0; m_wdata = '0; r_data = '0; r_hit = 1'b0;
      @(negedge clk);
      check({name, " req_ready"}, {31'd0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b1;
      bus.req_write = v.write;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.write ? v.wdata : '0;
      exp_q.push_back(v.exp_rdata);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      lat = 0; waited = 0; got_rsp = 0; saw_mem = 0; unstable = 0;
      while (!got_rsp && lat < 40) begin
         @(negedge clk);
         lat++;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = ~v.mem_rdata;
         if (bus.rsp_valid) begin
            got_rsp = 1;
            r_hit   = bus.rsp_hit;
            r_data  = bus.rsp_rdata;
         end else if (bus.mem_req) begin
            if (!saw_mem) begin
               m_addr = bus.mem_addr; m_write = bus.mem_write; m_wdata = bus.mem_wdata;
            end else if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata) unstable = 1;
            saw_mem = 1;
            if (waited == ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = v.mem_rdata;
            end
            waited++;
         end
      end
      e_data = exp_q.pop_front();
      check({name, " rsp_seen"}, {31'd0, got_rsp}, 32'd1);
      if (got_rsp) begin
         check({name, " rsp_hit"}, {31'd0, r_hit}, {31'd0, v.exp_hit});
         check({name, " rsp_rdata"}, {25'd0, r_data}, {25'd0, e_data});
         check({name, " latency"}, lat, exp_mem ? 3 + ack_delay : 2);
         check({name, " mem_req_seen"}, {31'd0, saw_mem}, {31'd0, exp_mem});
         if (saw_mem) begin
            check({name, " mem_addr"}, m_addr, v.addr);
            check({name, " mem_write"}, {31'd0, m_write}, {31'd0, v.write});
            check({name, " mem_stable"}, {31'd0, unstable}, 32'd0);
            if (v.write) check({name, " mem_wdata"}, {25'd0, m_wdata}, {25'd0, v.wdata});
         end
         check({name, " hit_count"}, bus.hit_count, v.exp_hits);
         check({name, " miss_count"}, bus.miss_count, v.exp_misses);
         @(negedge clk);
         check({name, " rsp_one_cycle"}, {31'd0, bus.rsp_valid}, 32'd0);
      end
   endtask

   initial begin
      vec_t v;
      int guard;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ack = 1'b0; bus.clear_stats = 1'b0;

      //        write addr           wdata  mrdata hit rdata  hits misses
      vecs[0]  = '{1'b0, 32'h0000_0104, 7'h00, 7'h15, 1'b0, 7'h15, 32'd0, 32'd1};
      vecs[1]  = '{1'b0, 32'h0000_0104, 7'h00, 7'h00, 1'b1, 7'h15, 32'd1, 32'd1};
      vecs[2]  = '{1'b0, 32'h0000_0504, 7'h00, 7'h21, 1'b0, 7'h21, 32'd1, 32'd2};
      vecs[3]  = '{1'b0, 32'h0000_0104, 7'h00, 7'h15, 1'b0, 7'h15, 32'd1, 32'd3};
      vecs[4]  = '{1'b1, 32'h0000_0200, 7'h2A, 7'h00, 1'b0, 7'h00, 32'd1, 32'd4};
      vecs[5]  = '{1'b0, 32'h0000_0200, 7'h00, 7'h2A, 1'b0, 7'h2A, 32'd1, 32'd5};
      vecs[6]  = '{1'b1, 32'h0000_0104, 7'h33, 7'h00, 1'b1, 7'h00, 32'd2, 32'd5};
      vecs[7]  = '{1'b0, 32'h0000_0104, 7'h00, 7'h00, 1'b1, 7'h33, 32'd3, 32'd5};
      vecs[8]  = '{1'b1, 32'h0000_0504, 7'h44, 7'h00, 1'b0, 7'h00, 32'd3, 32'd6};
      vecs[9]  = '{1'b0, 32'h0000_0504, 7'h00, 7'h00, 1'b1, 7'h44, 32'd4, 32'd6};
      vecs[10] = '{1'b0, 32'h0000_0104, 7'h00, 7'h12, 1'b0, 7'h12, 32'd4, 32'd7};
      vecs[11] = '{1'b0, 32'hFFFF_FFFF, 7'h00, 7'h7F, 1'b0, 7'h7F, 32'd4, 32'd8};
      vecs[12] = '{1'b0, 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b1, 7'h7F, 32'd5, 32'd8};
      vecs[13] = '{1'b0, 32'h0000_03FF, 7'h00, 7'h01, 1'b0, 7'h01, 32'd5, 32'd9};
      vecs[14] = '{1'b0, 32'hFFFF_FFFF, 7'h00, 7'h55, 1'b0, 7'h55, 32'd5, 32'd10};

      // Clock/reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("reset mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("reset mem_addr", bus.mem_addr, 32'd0);
      check("reset hit_count", bus.hit_count, 32'd0);
      check("reset miss_count", bus.miss_count, 32'd0);
      check("reset state", {29'd0, dbg_state}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) access(vecs[i], 0, $sformatf("vec%0d", i));

      // clear_stats alone, then held across an access so it overrides the increment.
      @(negedge clk);
      bus.clear_stats = 1'b1;
      @(negedge clk);
      check("clear hit_count", bus.hit_count, 32'd0);
      check("clear miss_count", bus.miss_count, 32'd0);
      v = '{1'b0, 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b1, 7'h55, 32'd0, 32'd0};
      access(v, 0, "clear_prio");
      bus.clear_stats = 1'b0;
      v = '{1'b0, 32'hFFFF_FFFF, 7'h00, 7'h00, 1'b1, 7'h55, 32'd1, 32'd0};
      access(v, 0, "after_clear");

      // Slow memory: mem_req must hold until the ack.
      v = '{1'b0, 32'h0000_0300, 7'h00, 7'h3C, 1'b0, 7'h3C, 32'd1, 32'd1};
      access(v, 3, "slow_rd");
      v = '{1'b1, 32'h0000_0300, 7'h11, 7'h00, 1'b1, 7'h00, 32'd2, 32'd1};
      access(v, 2, "slow_wr");
      v = '{1'b0, 32'h0000_0300, 7'h00, 7'h00, 1'b1, 7'h11, 32'd3, 32'd1};
      access(v, 0, "after_slow");

      // Stray mem_ack while idle has no effect.
      @(negedge clk);
      bus.mem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stray_ack idle", {31'd0, bus.req_ready}, 32'd1);
         check("stray_ack rsp", {31'd0, bus.rsp_valid}, 32'd0);
      end
      bus.mem_ack = 1'b0;
      check("stray_ack hit_count", bus.hit_count, 32'd3);
      check("stray_ack miss_count", bus.miss_count, 32'd1);

      // Reset while a load miss waits in MEM_RD.
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h0000_0704;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus.mem_req && guard < 10);
      check("rst_mid mem_req_reached", {31'd0, bus.mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_mid rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      check("rst_mid req_ready", {31'd0, bus.req_ready}, 32'd1);
      check("rst_mid hit_count", bus.hit_count, 32'd0);
      check("rst_mid miss_count", bus.miss_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      v = '{1'b0, 32'h0000_0300, 7'h00, 7'h22, 1'b0, 7'h22, 32'd0, 32'd1};
      access(v, 0, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
